calc_op_unit: RTL

CALC_OP_UNIT -- requirements
Module: calc_op_unit

---
 rtl/calc_op_unit.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/calc_op_unit.sv
// rtl/calc_op_unit.sv - multi-cycle signed 8-bit add/sub/mul/div unit with per-op result lanes
// Optional feature macro CALC_SAT_EN: overflowing results saturate to 0x7F/0x80 instead of wrapping.
module calc_op_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] add_y,
    output logic [7:0] sub_y,
    output logic [7:0] mul_y,
    output logic [7:0] div_y,
    output logic       ovf,
    output logic       dbz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_op;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [7:0]  r_mag_a;
    logic [7:0]  r_mag_b;
    logic [2:0]  r_cnt;
    logic [15:0] r_prod;
    logic [7:0]  r_dvd;
    logic [7:0]  r_rem;
    logic [7:0]  r_quo;
    logic [7:0]  r_add_y;
    logic [7:0]  r_sub_y;
    logic [7:0]  r_mul_y;
    logic [7:0]  r_div_y;
    logic        r_ovf;
    logic        r_dbz;

    logic [7:0]  w_mag_a;
    logic [7:0]  w_mag_b;
    logic [15:0] w_pp;
    logic [8:0]  w_rem_sh;
    logic [8:0]  w_rem_sub;
    logic        w_neg;
    logic [7:0]  w_sum;
    logic [7:0]  w_diff;
    logic [15:0] w_prod_s;
    logic [7:0]  w_quo_s;
    logic [7:0]  w_res;
    logic        w_ovf;
    logic        w_true_neg;
    logic        w_dbz;
    logic [7:0]  w_lane;

    // Operand magnitudes; |-128| = 0x80 is exact as an unsigned 8-bit value.
    assign w_mag_a = a[7] ? (~a + 8'd1) : a;
    assign w_mag_b = b[7] ? (~b + 8'd1) : b;

    assign w_pp      = r_mag_b[r_cnt] ? ({8'd0, r_mag_a} << r_cnt) : 16'd0;
    assign w_rem_sh  = {r_rem, r_dvd[7]};
    assign w_rem_sub = w_rem_sh - {1'b0, r_mag_b};

    assign w_neg    = r_a[7] ^ r_b[7];
    assign w_sum    = r_a + r_b;
    assign w_diff   = r_a - r_b;
    assign w_prod_s = w_neg ? (~r_prod + 16'd1) : r_prod;
    assign w_quo_s  = w_neg ? (~r_quo + 8'd1) : r_quo;
    assign w_dbz    = (r_op == OP_DIV) && (r_b == 8'd0);

    always_comb begin
        w_res      = 8'd0;
        w_ovf      = 1'b0;
        w_true_neg = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res      = w_sum;
                w_ovf      = (r_a[7] == r_b[7]) && (w_sum[7] != r_a[7]);
                w_true_neg = r_a[7];
            end
            OP_SUB: begin
                w_res      = w_diff;
                w_ovf      = (r_a[7] != r_b[7]) && (w_diff[7] != r_a[7]);
                w_true_neg = r_a[7];
            end
            OP_MUL: begin
                w_res      = w_prod_s[7:0];
                w_ovf      = (w_prod_s[15:7] != {9{w_prod_s[15]}});
                w_true_neg = w_neg && (r_prod != 16'd0);
            end
            default: begin
                w_res      = w_dbz ? 8'd0 : w_quo_s;
                w_ovf      = (r_a == 8'h80) && (r_b == 8'hFF);
                w_true_neg = w_neg;
            end
        endcase
    end

`ifdef CALC_SAT_EN
    assign w_lane = w_ovf ? (w_true_neg ? 8'h80 : 8'h7F) : w_res;
`else
    assign w_lane = w_res;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = op[1] ? S_ITER : S_SIGN;
                end
            end
            S_ITER: begin
                if (r_cnt == 3'd7) begin
                    w_next = S_SIGN;
                end
            end
            S_SIGN:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= 2'd0;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_mag_a <= 8'd0;
            r_mag_b <= 8'd0;
            r_cnt   <= 3'd0;
            r_prod  <= 16'd0;
            r_dvd   <= 8'd0;
            r_rem   <= 8'd0;
            r_quo   <= 8'd0;
            r_add_y <= 8'd0;
            r_sub_y <= 8'd0;
            r_mul_y <= 8'd0;
            r_div_y <= 8'd0;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_cnt   <= 3'd0;
                        r_prod  <= 16'd0;
                        r_dvd   <= w_mag_a;
                        r_rem   <= 8'd0;
                        r_quo   <= 8'd0;
                        r_add_y <= 8'd0;
                        r_sub_y <= 8'd0;
                        r_mul_y <= 8'd0;
                        r_div_y <= 8'd0;
                        r_ovf   <= 1'b0;
                        r_dbz   <= 1'b0;
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_op == OP_MUL) begin
                        r_prod <= r_prod + w_pp;
                    end else begin
                        // Restoring division, dividend consumed MSB first.
                        r_dvd <= {r_dvd[6:0], 1'b0};
                        if (w_rem_sh >= {1'b0, r_mag_b}) begin
                            r_rem <= w_rem_sub[7:0];
                            r_quo <= {r_quo[6:0], 1'b1};
                        end else begin
                            r_rem <= w_rem_sh[7:0];
                            r_quo <= {r_quo[6:0], 1'b0};
                        end
                    end
                end
                S_SIGN: begin
                    r_ovf <= w_ovf;
                    r_dbz <= w_dbz;
                    case (r_op)
                        OP_ADD:  r_add_y <= w_lane;
                        OP_SUB:  r_sub_y <= w_lane;
                        OP_MUL:  r_mul_y <= w_lane;
                        default: r_div_y <= w_lane;
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);
    assign add_y = r_add_y;
    assign sub_y = r_sub_y;
    assign mul_y = r_mul_y;
    assign div_y = r_div_y;
    assign ovf   = r_ovf;
    assign dbz   = r_dbz;

endmodule
